// File: rtl/bus_arb_pkg.sv
// Shared types for the split-capable bus arbiter: FSM states and initiator identifiers.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_M1    = 2'd1,
    GRANT_M2    = 2'd2,
    SPLIT_GRANT = 2'd3
  } arb_state_t;

  typedef enum logic {
    M1 = 1'b0,
    M2 = 1'b1
  } master_id_t;

  function automatic master_id_t other_master(input master_id_t id);
    return (id == M1) ? M2 : M1;
  endfunction

endpackage

// File: rtl/split_timeout_counter.sv
// Ages an outstanding split; expired is a combinational pulse on the cycle the
// SPLIT_TIMEOUT-th counted cycle is sampled, and the count restarts from zero.
module split_timeout_counter #(
  parameter int SPLIT_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(SPLIT_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(SPLIT_TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // clear has priority so a split_req arriving on the final cycle suppresses expiry
  always_comb begin
    expired = enable && !clear && (count_q == LAST_COUNT);
    count_d = count_q;
    if (clear || expired) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/split_bus_arbiter.sv
// Two-initiator round-robin bus arbiter that parks a split owner and hands the
// bus to the split target port when it asks to return data.
module split_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int SPLIT_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req_m1,
  input  logic req_m2,
  input  logic split_ack,
  input  logic split_req,
  output logic grant_m1,
  output logic grant_m2,
  output logic split_grant,
  output logic msel,
  output logic bus_busy,
  output logic split_timeout
);

  arb_state_t state_q, state_d;
  master_id_t last_q, last_d;
  master_id_t split_owner_q, split_owner_d;
  logic       split_pending_q, split_pending_d;

  logic grant_m1_q, grant_m1_d;
  logic grant_m2_q, grant_m2_d;
  logic split_grant_q, split_grant_d;
  logic msel_q, msel_d;
  logic bus_busy_q, bus_busy_d;
  logic split_timeout_q;

  logic elig_m1, elig_m2;
  logic tmo_enable, tmo_clear, tmo_expired;

  assign tmo_enable = split_pending_q && (state_q != SPLIT_GRANT);
  assign tmo_clear  = split_req || (state_q == SPLIT_GRANT);

  split_timeout_counter #(
    .SPLIT_TIMEOUT(SPLIT_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .enable (tmo_enable),
    .clear  (tmo_clear),
    .expired(tmo_expired)
  );

  // The parked split owner is masked out until its split completes or times out
  assign elig_m1 = req_m1 && !(split_pending_q && (split_owner_q == M1));
  assign elig_m2 = req_m2 && !(split_pending_q && (split_owner_q == M2));

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    split_owner_d   = split_owner_q;
    split_pending_d = split_pending_q;

    unique case (state_q)
      IDLE: begin
        if (split_pending_q && split_req) begin
          state_d = SPLIT_GRANT;
        end else if (elig_m1 && elig_m2) begin
          last_d  = other_master(last_q);
          state_d = (last_q == M1) ? GRANT_M2 : GRANT_M1;
        end else if (elig_m1) begin
          last_d  = M1;
          state_d = GRANT_M1;
        end else if (elig_m2) begin
          last_d  = M2;
          state_d = GRANT_M2;
        end
      end
      GRANT_M1: begin
        if (split_ack && !split_pending_q) begin
          split_pending_d = 1'b1;
          split_owner_d   = M1;
          state_d         = IDLE;
        end else if (!req_m1) begin
          state_d = IDLE;
        end
      end
      GRANT_M2: begin
        if (split_ack && !split_pending_q) begin
          split_pending_d = 1'b1;
          split_owner_d   = M2;
          state_d         = IDLE;
        end else if (!req_m2) begin
          state_d = IDLE;
        end
      end
      SPLIT_GRANT: begin
        if (!split_req) begin
          split_pending_d = 1'b0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tmo_expired) begin
      split_pending_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so every grant changes on the deciding edge
  always_comb begin
    split_grant_d = (state_d == SPLIT_GRANT);
    grant_m1_d    = (state_d == GRANT_M1) || (split_grant_d && (split_owner_d == M1));
    grant_m2_d    = (state_d == GRANT_M2) || (split_grant_d && (split_owner_d == M2));
    msel_d        = grant_m2_d;
    bus_busy_d    = grant_m1_d || grant_m2_d || split_grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      last_q          <= M2;
      split_owner_q   <= M1;
      split_pending_q <= 1'b0;
      grant_m1_q      <= 1'b0;
      grant_m2_q      <= 1'b0;
      split_grant_q   <= 1'b0;
      msel_q          <= 1'b0;
      bus_busy_q      <= 1'b0;
      split_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      split_owner_q   <= split_owner_d;
      split_pending_q <= split_pending_d;
      grant_m1_q      <= grant_m1_d;
      grant_m2_q      <= grant_m2_d;
      split_grant_q   <= split_grant_d;
      msel_q          <= msel_d;
      bus_busy_q      <= bus_busy_d;
      split_timeout_q <= tmo_expired;
    end
  end

  assign grant_m1      = grant_m1_q;
  assign grant_m2      = grant_m2_q;
  assign split_grant   = split_grant_q;
  assign msel          = msel_q;
  assign bus_busy      = bus_busy_q;
  assign split_timeout = split_timeout_q;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Bench for split_bus_arbiter: directed vector table for the scenarios of interest,
// then randomized traffic compared each cycle against a transaction-level model.
module tb_split_bus_arbiter;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst, req_m1, req_m2, split_ack, split_req;
  logic grant_m1, grant_m2, split_grant, msel, bus_busy, split_timeout;

  split_bus_arbiter #(.SPLIT_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_m1       (req_m1),
    .req_m2       (req_m2),
    .split_ack    (split_ack),
    .split_req    (split_req),
    .grant_m1     (grant_m1),
    .grant_m2     (grant_m2),
    .split_grant  (split_grant),
    .msel         (msel),
    .bus_busy     (bus_busy),
    .split_timeout(split_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // expected vector layout: {grant_m1, grant_m2, split_grant, msel, bus_busy, split_timeout}
  typedef struct {
    bit         rst, r1, r2, ack, sr;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rs, bit r1, bit r2, bit ack, bit sr, logic [5:0] e);
    vec_t v;
    v.rst = rs; v.r1 = r1; v.r2 = r2; v.ack = ack; v.sr = sr; v.exp = e;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {grant_m1, grant_m2, split_grant, msel, bus_busy, split_timeout};
  endfunction

  task automatic check(input string name, input int idx, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s #%0d: got g1,g2,sg,msel,busy,to=%b expected %b", name, idx, got, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic drive(input bit rs, input bit r1, input bit r2, input bit ack, input bit sr);
    rst = rs; req_m1 = r1; req_m2 = r2; split_ack = ack; split_req = sr;
  endtask

  // Transaction-level reference: who holds the bus, who is parked, and how long it has waited
  int m_owner;   // 0 none, 1 initiator 1, 2 initiator 2
  int m_parked;  // 0 none, else the initiator whose split is outstanding
  int m_prefer;  // initiator that wins the next tie
  int m_wait;
  bit m_split, m_to;

  task automatic model_step(input bit rs, input bit r1, input bit r2, input bit ack, input bit sr);
    int  nparked;
    bit  expire;
    bit  want1, want2;
    if (rs) begin
      m_owner = 0; m_parked = 0; m_prefer = 1; m_wait = 0; m_split = 0; m_to = 0;
      return;
    end
    nparked = m_parked;
    expire  = 0;
    m_to    = 0;
    if (sr || m_split) begin
      m_wait = 0;
    end else if (m_parked != 0) begin
      m_wait++;
      if (m_wait == TMO) begin
        expire = 1;
        m_wait = 0;
      end
    end
    if (m_split) begin
      if (!sr) begin
        m_split = 0;
        nparked = 0;
      end
    end else if (m_owner != 0) begin
      if (ack && m_parked == 0) begin
        nparked = m_owner;
        m_owner = 0;
      end else if (!((m_owner == 1) ? r1 : r2)) begin
        m_owner = 0;
      end
    end else if (m_parked != 0 && sr) begin
      m_split = 1;
    end else begin
      want1 = r1 && (m_parked != 1);
      want2 = r2 && (m_parked != 2);
      if (want1 && want2) m_owner = m_prefer;
      else if (want1)     m_owner = 1;
      else if (want2)     m_owner = 2;
      if (m_owner != 0) m_prefer = 3 - m_owner;
    end
    if (expire) begin
      nparked = 0;
      m_to    = 1;
    end
    m_parked = nparked;
  endtask

  function automatic logic [5:0] model_outs();
    bit g1, g2;
    g1 = (m_owner == 1) || (m_split && m_parked == 1);
    g2 = (m_owner == 2) || (m_split && m_parked == 2);
    return {g1, g2, m_split, g2, (g1 | g2 | m_split), m_to};
  endfunction

  initial begin
    bit r1, r2, sr, ack, rs;

    drive(1, 0, 0, 0, 0);

    // reset, then a single initiator-1 transaction of 5 cycles
    vecs.push_back(mk(1, 0, 0, 0, 0, 6'b000000));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 6'b100010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000000));
    // both requesting: alternation with an idle turnaround between owners
    vecs.push_back(mk(0, 1, 1, 0, 0, 6'b010110));
    vecs.push_back(mk(0, 1, 1, 0, 0, 6'b010110));
    vecs.push_back(mk(0, 1, 0, 0, 0, 6'b000000));
    vecs.push_back(mk(0, 1, 1, 0, 0, 6'b100010));
    vecs.push_back(mk(0, 1, 1, 0, 0, 6'b100010));
    vecs.push_back(mk(0, 0, 1, 0, 0, 6'b000000));
    vecs.push_back(mk(0, 1, 1, 0, 0, 6'b010110));
    vecs.push_back(mk(0, 1, 0, 0, 0, 6'b000000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000000));
    // initiator 2 split, initiator 1 served meanwhile, then split return
    vecs.push_back(mk(0, 0, 1, 0, 0, 6'b010110));
    vecs.push_back(mk(0, 0, 1, 1, 0, 6'b000000));
    vecs.push_back(mk(0, 1, 1, 0, 0, 6'b100010));
    vecs.push_back(mk(0, 1, 1, 0, 1, 6'b100010));
    vecs.push_back(mk(0, 0, 1, 0, 1, 6'b000000));
    vecs.push_back(mk(0, 0, 1, 0, 1, 6'b011110));
    vecs.push_back(mk(0, 0, 0, 0, 1, 6'b011110));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000000));
    // split_ack with req falling; then split_req and req_m1 together in IDLE
    vecs.push_back(mk(0, 1, 0, 0, 0, 6'b100010));
    vecs.push_back(mk(0, 0, 0, 1, 0, 6'b000000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 6'b101010));
    vecs.push_back(mk(0, 1, 0, 0, 0, 6'b000000));
    vecs.push_back(mk(0, 1, 0, 0, 0, 6'b100010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000000));
    // abandoned split: timeout after 4 counted cycles, parked initiator granted next
    vecs.push_back(mk(0, 1, 0, 0, 0, 6'b100010));
    vecs.push_back(mk(0, 1, 0, 1, 0, 6'b000000));
    vecs.push_back(mk(0, 1, 0, 0, 0, 6'b000000));
    vecs.push_back(mk(0, 1, 0, 0, 0, 6'b000000));
    vecs.push_back(mk(0, 1, 0, 0, 0, 6'b000000));
    vecs.push_back(mk(0, 1, 0, 0, 0, 6'b000001));
    vecs.push_back(mk(0, 1, 0, 0, 0, 6'b100010));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000000));
    // reset during SPLIT_GRANT forgets the split
    vecs.push_back(mk(0, 0, 1, 0, 0, 6'b010110));
    vecs.push_back(mk(0, 0, 1, 1, 0, 6'b000000));
    vecs.push_back(mk(0, 0, 0, 0, 1, 6'b011110));
    vecs.push_back(mk(1, 0, 0, 0, 1, 6'b000000));
    vecs.push_back(mk(0, 0, 0, 0, 1, 6'b000000));
    vecs.push_back(mk(0, 0, 0, 0, 1, 6'b000000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000000));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].r1, vecs[i].r2, vecs[i].ack, vecs[i].sr);
      @(posedge clk);
      #1;
      check("vector", i, outs(), vecs[i].exp);
    end

    // randomized traffic against the reference model
    r1 = 0; r2 = 0; sr = 0;
    for (int c = 0; c < 3000; c++) begin
      rs  = (c == 0) || ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 4) == 0) r1 = ~r1;
      if ($urandom_range(0, 4) == 0) r2 = ~r2;
      if ($urandom_range(0, 5) == 0) sr = ~sr;
      ack = ($urandom_range(0, 6) == 0);
      drive(rs, r1, r2, ack, sr);
      model_step(rs, r1, r2, ack, sr);
      @(posedge clk);
      #1;
      check("random", c, outs(), model_outs());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
